// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - MIPS instruction-fetch stage: PC, imem req/ack fetch, next-PC on retire
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180,
    parameter int unsigned MAX_WAIT   = 255
) (
    input  logic        clock,
    input  logic        reset,
    output logic [29:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] inst_pc,
    input  logic        retire,
    input  logic [1:0]  control_type,
    input  logic        zero,
    input  logic [31:0] rs_data,
    input  logic        except,
    output logic [31:0] epc,
    output logic        bus_error,
    output logic [31:0] retire_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } state_t;

    // Wait-counter value during the last REQ cycle allowed before timing out.
    localparam logic [31:0] WAIT_LAST = 32'(MAX_WAIT - 1);

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] wait_cnt;

    logic [31:0] pc4;
    logic [31:0] branch_off;
    logic        branch_taken;
    logic [31:0] pc_next;

    assign imem_addr = pc[31:2];

    // State register; reset returns to IDLE at once, regardless of the clock.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; handshake outputs depend on the registered state only.
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        inst_valid = 1'b0;
        bus_error  = 1'b0;
        case (state)
            IDLE: begin
                state_next = REQ;
            end
            REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_next = HOLD;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next = FAULT;
                end
            end
            HOLD: begin
                inst_valid = 1'b1;
                if (retire) begin
                    state_next = REQ;
                end
            end
            FAULT: begin
                bus_error = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Next-PC selection for the instruction being retired; exceptions override everything.
    always_comb begin
        pc4          = inst_pc + 32'd4;
        branch_off   = {{14{inst[15]}}, inst[15:0], 2'b00};
        branch_taken = ((inst[31:26] == 6'h04) && zero) ||
                       ((inst[31:26] == 6'h05) && !zero);
        pc_next      = pc4;
        if (except) begin
            pc_next = EXC_VECTOR;
        end else begin
            case (control_type)
                2'b00: pc_next = pc4;
                2'b01: pc_next = branch_taken ? (pc4 + branch_off) : pc4;
                2'b10: pc_next = {pc4[31:28], inst[25:0], 2'b00};
                2'b11: pc_next = rs_data & 32'hFFFF_FFFC;
                default: pc_next = pc4;
            endcase
        end
    end

    // Datapath: capture fetched words, count wait cycles, and commit PC/EPC/count on retire.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc           <= RESET_PC;
            inst         <= 32'd0;
            inst_pc      <= 32'd0;
            epc          <= 32'd0;
            retire_count <= 32'd0;
            wait_cnt     <= 32'd0;
        end else begin
            case (state)
                REQ: begin
                    if (imem_ack) begin
                        inst     <= imem_rdata;
                        inst_pc  <= pc;
                        wait_cnt <= 32'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                HOLD: begin
                    if (retire) begin
                        pc           <= pc_next;
                        retire_count <= retire_count + 32'd1;
                        if (except) begin
                            epc <= inst_pc;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [29:0] imem_addr;
    logic        imem_req;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic        retire = 1'b0;
    logic [1:0]  control_type = 2'b00;
    logic        zero = 1'b0;
    logic [31:0] rs_data = 32'd0;
    logic        except = 1'b0;
    logic [31:0] epc;
    logic        bus_error;
    logic [31:0] retire_count;

    int checks = 0;
    int errors = 0;
    int exp_retires = 0;

    fetch_unit #(
        .RESET_PC  (32'h0040_0000),
        .EXC_VECTOR(32'h8000_0180),
        .MAX_WAIT  (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .inst        (inst),
        .inst_valid  (inst_valid),
        .inst_pc     (inst_pc),
        .retire      (retire),
        .control_type(control_type),
        .zero        (zero),
        .rs_data     (rs_data),
        .except      (except),
        .epc         (epc),
        .bus_error   (bus_error),
        .retire_count(retire_count)
    );

    always #5 clock = ~clock;

    // Wait (bounded) for a request, then ack after 'waits' extra REQ cycles.
    task automatic serve(input logic [31:0] word, input int waits, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (ok) begin
            repeat (waits) @(negedge clock);
            imem_ack   = 1'b1;
            imem_rdata = word;
            @(negedge clock);
            imem_ack   = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
        end
    endtask

    task automatic do_retire(input logic [1:0] ct, input logic z, input logic [31:0] rs, input logic ex);
        retire       = 1'b1;
        control_type = ct;
        zero         = z;
        rs_data      = rs;
        except       = ex;
        @(negedge clock);
        retire       = 1'b0;
        control_type = 2'b00;
        zero         = 1'b0;
        rs_data      = 32'd0;
        except       = 1'b0;
        exp_retires++;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem_req); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", inst_valid); end
        checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL rst_bus_error got %b exp 0", bus_error); end
        checks++; if (inst !== 32'd0) begin errors++; $display("FAIL rst_inst got %h exp 0", inst); end
        checks++; if (inst_pc !== 32'd0) begin errors++; $display("FAIL rst_inst_pc got %h exp 0", inst_pc); end
        checks++; if (epc !== 32'd0) begin errors++; $display("FAIL rst_epc got %h exp 0", epc); end
        checks++; if (retire_count !== 32'd0) begin errors++; $display("FAIL rst_count got %h exp 0", retire_count); end
        checks++; if (imem_addr !== 30'h0010_0000) begin errors++; $display("FAIL rst_addr got %h exp 100000", imem_addr); end
        // pending ack during the IDLE cycle must be ignored
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_0000;
        reset      = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_req got %b exp 0", imem_req); end
        @(negedge clock);
        imem_ack = 1'b0;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req got %b exp 1", imem_req); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL idle_ack_ignored got %b exp 0", inst_valid); end
    endtask

    task automatic test_sequential;
        bit ok;
        logic [31:0] word;
        for (int k = 0; k < 3; k++) begin
            word = 32'h2000_0000 | 32'(k);
            checks++; if (imem_addr !== 30'h0010_0000 + 30'(k)) begin errors++; $display("FAIL seq_addr%0d got %h exp %h", k, imem_addr, 30'h0010_0000 + 30'(k)); end
            serve(word, 0, ok);
            checks++; if (!ok) begin errors++; $display("FAIL seq_req_timeout%0d got 0 exp 1", k); end
            checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL seq_valid%0d got %b exp 1", k, inst_valid); end
            checks++; if (inst !== word) begin errors++; $display("FAIL seq_inst%0d got %h exp %h", k, inst, word); end
            checks++; if (inst_pc !== 32'h0040_0000 + 32'(4 * k)) begin errors++; $display("FAIL seq_inst_pc%0d got %h exp %h", k, inst_pc, 32'h0040_0000 + 32'(4 * k)); end
            do_retire(2'b00, 1'b0, 32'd0, 1'b0);
            checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL seq_b2b_req%0d got %b exp 1", k, imem_req); end
        end
        checks++; if (retire_count !== 32'd3) begin errors++; $display("FAIL seq_count got %0d exp 3", retire_count); end
    endtask

    task automatic test_branch;
        bit ok;
        serve(32'h0000_0000, 0, ok);
        do_retire(2'b00, 1'b0, 32'd0, 1'b0);
        checks++; if (imem_addr !== 30'h0010_0004) begin errors++; $display("FAIL br_pre_addr got %h exp 100004", imem_addr); end
        serve(32'h1022_FFFE, 0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL br_req_timeout got 0 exp 1"); end
        checks++; if (inst_pc !== 32'h0040_0010) begin errors++; $display("FAIL beq_inst_pc got %h exp 00400010", inst_pc); end
        do_retire(2'b01, 1'b1, 32'd0, 1'b0);
        checks++; if (imem_addr !== 30'h0010_0003) begin errors++; $display("FAIL beq_taken got %h exp 100003", imem_addr); end
        serve(32'h0000_0000, 0, ok);
        do_retire(2'b00, 1'b0, 32'd0, 1'b0);
        serve(32'h1422_FFFE, 0, ok);
        checks++; if (inst_pc !== 32'h0040_0010) begin errors++; $display("FAIL bne_inst_pc got %h exp 00400010", inst_pc); end
        do_retire(2'b01, 1'b1, 32'd0, 1'b0);
        checks++; if (imem_addr !== 30'h0010_0005) begin errors++; $display("FAIL bne_not_taken got %h exp 100005", imem_addr); end
    endtask

    task automatic test_jump;
        bit ok;
        for (int k = 0; k < 3; k++) begin
            serve(32'h0000_0000, 0, ok);
            do_retire(2'b00, 1'b0, 32'd0, 1'b0);
        end
        checks++; if (imem_addr !== 30'h0010_0008) begin errors++; $display("FAIL j_pre_addr got %h exp 100008", imem_addr); end
        serve(32'h0810_0004, 0, ok);
        checks++; if (inst_pc !== 32'h0040_0020) begin errors++; $display("FAIL j_inst_pc got %h exp 00400020", inst_pc); end
        do_retire(2'b10, 1'b0, 32'd0, 1'b0);
        checks++; if (imem_addr !== 30'h0010_0004) begin errors++; $display("FAIL j_target got %h exp 100004", imem_addr); end
        serve(32'h03E0_0008, 0, ok);
        do_retire(2'b11, 1'b0, 32'h1000_0007, 1'b0);
        checks++; if (imem_addr !== 30'h0400_0001) begin errors++; $display("FAIL jr_target got %h exp 4000001", imem_addr); end
    endtask

    task automatic test_exception;
        bit ok;
        serve(32'h0000_0000, 0, ok);
        do_retire(2'b11, 1'b0, 32'h0040_0008, 1'b0);
        checks++; if (imem_addr !== 30'h0010_0002) begin errors++; $display("FAIL exc_pre_addr got %h exp 100002", imem_addr); end
        serve(32'h0810_0004, 0, ok);
        checks++; if (inst_pc !== 32'h0040_0008) begin errors++; $display("FAIL exc_inst_pc got %h exp 00400008", inst_pc); end
        do_retire(2'b10, 1'b0, 32'd0, 1'b1);
        checks++; if (imem_addr !== 30'h2000_0060) begin errors++; $display("FAIL exc_vector got %h exp 20000060", imem_addr); end
        checks++; if (epc !== 32'h0040_0008) begin errors++; $display("FAIL exc_epc got %h exp 00400008", epc); end
        checks++; if (retire_count !== 32'(exp_retires)) begin errors++; $display("FAIL exc_count got %0d exp %0d", retire_count, exp_retires); end
    endtask

    task automatic test_stall;
        bit ok;
        serve(32'h1234_5678, 0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stall_req_timeout got 0 exp 1"); end
        for (int i = 0; i < 10; i++) begin
            control_type = i[1:0];
            zero         = i[0];
            except       = ~i[0];
            rs_data      = 32'hA5A5_0000 + 32'(i);
            imem_ack     = i[0];
            imem_rdata   = 32'hFFFF_0000 | 32'(i);
            @(negedge clock);
            checks++; if (inst !== 32'h1234_5678) begin errors++; $display("FAIL stall_inst%0d got %h exp 12345678", i, inst); end
            checks++; if (inst_pc !== 32'h8000_0180) begin errors++; $display("FAIL stall_inst_pc%0d got %h exp 80000180", i, inst_pc); end
            checks++; if (imem_addr !== 30'h2000_0060) begin errors++; $display("FAIL stall_pc%0d got %h exp 20000060", i, imem_addr); end
            checks++; if (retire_count !== 32'(exp_retires)) begin errors++; $display("FAIL stall_count%0d got %0d exp %0d", i, retire_count, exp_retires); end
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req%0d got %b exp 0", i, imem_req); end
            checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL stall_valid%0d got %b exp 1", i, inst_valid); end
            checks++; if (epc !== 32'h0040_0008) begin errors++; $display("FAIL stall_epc%0d got %h exp 00400008", i, epc); end
        end
        control_type = 2'b00;
        zero         = 1'b0;
        except       = 1'b0;
        rs_data      = 32'd0;
        imem_ack     = 1'b0;
        do_retire(2'b00, 1'b0, 32'd0, 1'b0);
        checks++; if (imem_addr !== 30'h2000_0061) begin errors++; $display("FAIL stall_resume got %h exp 20000061", imem_addr); end
    endtask

    task automatic test_wait_states;
        for (int c = 1; c < 4; c++) begin
            checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL wait_req%0d got %b exp 1", c, imem_req); end
            checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL wait_valid%0d got %b exp 0", c, inst_valid); end
            @(negedge clock);
        end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL wait_req4 got %b exp 1", imem_req); end
        imem_ack   = 1'b1;
        imem_rdata = 32'hCAFE_0001;
        @(negedge clock);
        imem_ack   = 1'b0;
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL wait_valid_rise got %b exp 1", inst_valid); end
        checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL wait_ack_wins got %b exp 0", bus_error); end
        checks++; if (inst !== 32'hCAFE_0001) begin errors++; $display("FAIL wait_inst got %h exp cafe0001", inst); end
        checks++; if (inst_pc !== 32'h8000_0184) begin errors++; $display("FAIL wait_inst_pc got %h exp 80000184", inst_pc); end
        do_retire(2'b00, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic test_timeout;
        for (int c = 1; c <= 4; c++) begin
            checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL to_req%0d got %b exp 1", c, imem_req); end
            checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL to_early%0d got %b exp 0", c, bus_error); end
            @(negedge clock);
        end
        checks++; if (bus_error !== 1'b1) begin errors++; $display("FAIL to_bus_error got %b exp 1", bus_error); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL to_req_low got %b exp 0", imem_req); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL to_valid got %b exp 0", inst_valid); end
        retire   = 1'b1;
        imem_ack = 1'b1;
        repeat (3) @(negedge clock);
        checks++; if (bus_error !== 1'b1) begin errors++; $display("FAIL to_sticky got %b exp 1", bus_error); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL to_sticky_req got %b exp 0", imem_req); end
        retire   = 1'b0;
        imem_ack = 1'b0;
    endtask

    task automatic test_reset_in_fault;
        #2;
        reset = 1'b0;
        #1;
        checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL arst_bus_error got %b exp 0", bus_error); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL arst_req got %b exp 0", imem_req); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b exp 0", inst_valid); end
        checks++; if (inst !== 32'd0) begin errors++; $display("FAIL arst_inst got %h exp 0", inst); end
        checks++; if (inst_pc !== 32'd0) begin errors++; $display("FAIL arst_inst_pc got %h exp 0", inst_pc); end
        checks++; if (epc !== 32'd0) begin errors++; $display("FAIL arst_epc got %h exp 0", epc); end
        checks++; if (retire_count !== 32'd0) begin errors++; $display("FAIL arst_count got %h exp 0", retire_count); end
        checks++; if (imem_addr !== 30'h0010_0000) begin errors++; $display("FAIL arst_addr got %h exp 100000", imem_addr); end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL arst_restart_req got %b exp 1", imem_req); end
        checks++; if (imem_addr !== 30'h0010_0000) begin errors++; $display("FAIL arst_restart_addr got %h exp 100000", imem_addr); end
    endtask

    initial begin
        test_reset;
        test_sequential;
        test_branch;
        test_jump;
        test_exception;
        test_stall;
        test_wait_states;
        test_timeout;
        test_reset_in_fault;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
